// File: rtl/mult_div_unit.sv
// mult_div_unit: 32-cycle iterative signed/unsigned multiply and restoring divide with HI/LO results.
module mult_div_unit #(
  parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Start,
  input  logic [5:0]  Funct,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] mag_q, mag_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic        div_q, div_d, bz_q, bz_d, neg_q, neg_d, a_neg_q, a_neg_d, dz_q, dz_d;
  logic        accept, sgn, step, dz;
  logic [31:0] abs_a, abs_b, div_rem;
  logic [32:0] mul_sum, div_sh;
  logic        div_ge;
  logic [63:0] run_acc, fix_acc;
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mag_q   <= '0;
      a_q     <= '0;
      div_q   <= 1'b0;
      bz_q    <= 1'b0;
      neg_q   <= 1'b0;
      a_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mag_q   <= mag_d;
      a_q     <= a_d;
      div_q   <= div_d;
      bz_q    <= bz_d;
      neg_q   <= neg_d;
      a_neg_q <= a_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end
  // RUN holds one extra cycle at cnt==0 so Done lands 34 edges after the accepting edge
  always_comb begin
    accept  = Start && Funct[5:2] == 4'b0110 && (state_q == IDLE || state_q == DONE);
    step    = state_q == RUN && cnt_q != 6'd0;
    state_d = accept ? RUN :
              state_q == RUN ? (cnt_q == 6'd0 ? FIX : RUN) :
              state_q == FIX ? DONE : IDLE;
  end
  always_comb begin
    Busy    = state_q == RUN || state_q == FIX;
    Done    = state_q == DONE;
    Hi      = hi_q;
    Lo      = lo_q;
    DivZero = dz_q;
  end
  always_comb begin
    sgn     = ~Funct[0];
    abs_a   = (sgn && A[31]) ? -A : A;
    abs_b   = (sgn && B[31]) ? -B : B;
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_q} : 33'd0);
    div_sh  = {acc_q[63:32], acc_q[31]};
    div_ge  = div_sh >= {1'b0, mag_q};
    div_rem = div_ge ? 32'(div_sh - {1'b0, mag_q}) : div_sh[31:0];
    run_acc = div_q ? {div_rem, acc_q[30:0], div_ge} : {mul_sum, acc_q[31:1]};
    fix_acc = div_q ? {a_neg_q ? -acc_q[63:32] : acc_q[63:32], neg_q ? -acc_q[31:0] : acc_q[31:0]}
                    : (neg_q ? -acc_q : acc_q);
    dz      = div_q && bz_q;
    acc_d   = accept ? {32'd0, abs_a} : step ? run_acc : acc_q;
    cnt_d   = accept ? 6'd32 : step ? cnt_q - 6'd1 : cnt_q;
    mag_d   = accept ? abs_b : mag_q;
    a_d     = accept ? A : a_q;
    div_d   = accept ? Funct[1] : div_q;
    bz_d    = accept ? B == 32'd0 : bz_q;
    neg_d   = accept ? sgn && (A[31] ^ B[31]) : neg_q;
    a_neg_d = accept ? sgn && A[31] : a_neg_q;
    hi_d    = state_q == FIX ? (dz ? a_q : fix_acc[63:32]) : hi_q;
    lo_d    = state_q == FIX ? (dz ? DIV0_LO : fix_acc[31:0]) : lo_q;
    dz_d    = accept ? 1'b0 : state_q == FIX ? dz : dz_q;
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
  logic        Clk, Clr, Start, Busy, Done, DivZero;
  logic [5:0]  Funct;
  logic [31:0] A, B, Hi, Lo;
  logic [31:0] last_hi, last_lo;
  int checks, fails;
  mult_div_unit dut (
    .Clk(Clk), .Clr(Clr), .Start(Start), .Funct(Funct), .A(A), .B(B),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .DivZero(DivZero)
  );
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z = 1'b0;
    p = '0;
    h = '0;
    l = '0;
    if (f == MULT) p = 64'(sa * sb);
    else if (f == MULTU) p = {32'd0, a} * {32'd0, b};
    if (f == MULT || f == MULTU) begin
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'd0) begin
      h = a;
      l = 32'hFFFF_FFFF;
      z = 1'b1;
    end else if (f == DIV) begin
      h = 32'(sa % sb);
      l = 32'(sa / sb);
    end else begin
      h = a % b;
      l = a / b;
    end
  endfunction
  task automatic op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input int pulse_at);
    logic [31:0] eh, el;
    logic ez;
    int k;
    model(f, a, b, eh, el, ez);
    @(negedge Clk);
    Start = 1'b1; Funct = f; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0; Funct = 6'($urandom); A = $urandom; B = $urandom;
    check("busy_on_accept", 64'(Busy), 64'd1);
    check("divzero_cleared", 64'(DivZero), 64'd0);
    k = 0;
    while (!Done && k < 60) begin
      if (k == pulse_at) begin
        @(negedge Clk);
        Start = 1'b1; Funct = DIVU; A = $urandom; B = $urandom;
      end
      @(posedge Clk); #1;
      Start = 1'b0;
      k++;
    end
    check("latency", 64'(k), 64'd34);
    check("hi", 64'(Hi), 64'(eh));
    check("lo", 64'(Lo), 64'(el));
    check("divzero", 64'(DivZero), 64'(ez));
    check("busy_at_done", 64'(Busy), 64'd0);
    @(posedge Clk); #1;
    check("done_one_cycle", 64'(Done), 64'd0);
    check("hi_hold", 64'(Hi), 64'(eh));
    last_hi = eh;
    last_lo = el;
  endtask
  function automatic logic [31:0] pick();
    logic [31:0] sp [5];
    sp[0] = 32'd0; sp[1] = 32'd1; sp[2] = 32'h8000_0000; sp[3] = 32'hFFFF_FFFF; sp[4] = 32'h7FFF_FFFF;
    return ($urandom_range(0, 2) == 0) ? sp[$urandom_range(0, 4)] : 32'($urandom);
  endfunction
  initial begin
    int seen;
    logic [5:0] fs [4];
    checks = 0; fails = 0;
    fs[0] = MULT; fs[1] = MULTU; fs[2] = DIV; fs[3] = DIVU;
    Clr = 1'b1; Start = 1'b0; Funct = '0; A = '0; B = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_hi", 64'(Hi), 64'd0);
    check("rst_lo", 64'(Lo), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_divzero", 64'(DivZero), 64'd0);
    @(negedge Clk); Clr = 1'b0;
    op(MULT, 32'hFFFF_FFFD, 32'd7, -1);
    op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    op(DIV, 32'hFFFF_FFF9, 32'd2, -1);
    op(DIVU, 32'd100, 32'd7, -1);
    op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    op(DIVU, 32'd5, 32'd0, -1);
    op(MULT, 32'd3, 32'd4, -1);
    op(DIV, 32'h8000_0007, 32'd0, -1);
    for (int i = 0; i < 24; i++) op(fs[$urandom_range(0, 3)], pick(), pick(), -1);
    op(MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 9);
    @(negedge Clk);
    Start = 1'b1; Funct = 6'b101010; A = 32'd9; B = 32'd9;
    @(posedge Clk); #1;
    Start = 1'b0;
    check("invalid_busy", 64'(Busy), 64'd0);
    repeat (3) @(posedge Clk);
    #1;
    check("invalid_done", 64'(Done), 64'd0);
    check("invalid_hi", 64'(Hi), 64'(last_hi));
    check("invalid_lo", 64'(Lo), 64'(last_lo));
    @(negedge Clk);
    Start = 1'b1; Funct = MULT; A = 32'd11; B = 32'd13;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (19) @(posedge Clk);
    @(negedge Clk); Clr = 1'b1;
    @(posedge Clk); #1;
    Clr = 1'b0;
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_hi", 64'(Hi), 64'd0);
    check("abort_lo", 64'(Lo), 64'd0);
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge Clk); #1;
      if (Done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    op(DIV, 32'd1000, 32'hFFFF_FFFD, -1);
    @(negedge Clk);
    Clr = 1'b1; Start = 1'b1; Funct = MULT; A = 32'd2; B = 32'd2;
    @(posedge Clk); #1;
    Clr = 1'b0; Start = 1'b0;
    check("clr_priority_busy", 64'(Busy), 64'd0);
    @(posedge Clk); #1;
    check("clr_priority_busy2", 64'(Busy), 64'd0);
    check("clr_priority_lo", 64'(Lo), 64'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
